// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubble, branch squash, dmem freeze.
// Optional PERF_COUNTERS_EN adds saturating stall/flush/wait counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        mem_branch_taken,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        pipe_freeze,
    output logic        mem_req,
    output logic        mem_err,
    output logic [1:0]  state
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
`endif
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_params
        $error("pipeline_hazard_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             mem_err_r;
    logic             wait_s;
    logic             branch_s;
    logic             lu_s;

    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] dst,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        load_use_hit = mem_read && (dst != 5'd0) &&
                       ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

    // Event classification in priority order; the MEM_WAIT exit cycle is treated like RUN.
    always_comb begin
        wait_s   = 1'b0;
        branch_s = 1'b0;
        lu_s     = 1'b0;
        if (state_r == ST_MEM_WAIT) begin
            wait_s = !dmem_ready;
        end else begin
            wait_s = mem_access && !dmem_ready;
        end
        branch_s = mem_branch_taken && !wait_s;
        if ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) begin
            lu_s = !wait_s && !branch_s &&
                   load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
        end else begin
            lu_s = 1'b0;
        end
    end

    // Same-cycle control outputs and next-state selection.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;
        mem_req      = mem_access;
        state_nxt_s  = ST_RUN;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_req      = 1'b0;
            state_nxt_s  = ST_RUN;
        end else if (wait_s) begin
            pipe_freeze  = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            state_nxt_s  = ST_MEM_WAIT;
        end else if (branch_s) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_nxt_s  = ST_FLUSH;
        end else if (lu_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            state_nxt_s  = ST_LU_STALL;
        end else begin
            state_nxt_s  = ST_RUN;
        end
    end

    // FSM state, timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_RUN;
            tmo_cnt_r <= {TMO_W{1'b0}};
            mem_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (wait_s) begin
                // Counts every frozen cycle, including the one that enters MEM_WAIT.
                if (tmo_cnt_r == TMO_LAST) begin
                    mem_err_r <= 1'b1;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
        end
    end

    assign state   = state_r;
    assign mem_err = mem_err_r;

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] wait_cnt_r;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
            wait_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (!pc_write && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (branch_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
            if ((state_r == ST_MEM_WAIT) && (wait_cnt_r != {CNT_W{1'b1}})) begin
                wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
    assign wait_cnt  = wait_cnt_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default MEM_TIMEOUT=16).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, mem_branch_taken, mem_access, dmem_ready;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic       pipe_freeze, mem_req, mem_err;
    logic [1:0] state;
`ifdef PERF_COUNTERS_EN
    logic [15:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pipe_freeze(pipe_freeze),
        .mem_req(mem_req), .mem_err(mem_err), .state(state)
`ifdef PERF_COUNTERS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Outputs packed as {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze, mem_req}
    localparam logic [6:0] O_DEF   = 7'b1100000;
    localparam logic [6:0] O_RST   = 7'b0011100;
    localparam logic [6:0] O_LU    = 7'b0001000;
    localparam logic [6:0] O_BR    = 7'b1111100;
    localparam logic [6:0] O_WAIT  = 7'b0000011;
    localparam logic [6:0] O_DEFMR = 7'b1100001;

    task automatic chk_outs(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze, mem_req};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s outs observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        n_checks++;
        assert (state === exp) else begin
            n_fail++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp);
        end
    endtask

    task automatic chk_err(input string tag, input logic exp);
        n_checks++;
        assert (mem_err === exp) else begin
            n_fail++;
            $error("FAIL %s mem_err observed=%b expected=%b", tag, mem_err, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
        mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        mem_access = 1'b1;
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        chk_outs("reset_outs", O_RST);
        tick();
        chk_state("reset_state", 2'd0);
        chk_err("reset_err", 1'b0);
        reset = 1'b0;
        clear_inputs();
        chk_outs("idle_defaults", O_DEF);

        // lw $2 then add using $2 as rs
        ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
        chk_outs("lu_rs_stall", O_LU);
        tick();
        chk_state("lu_state1", 2'd1);
        chk_outs("lu_stall_defaults", O_DEF);
        tick();
        chk_state("lu_back_run", 2'd0);

        // $0 destination never stalls
        ex_rt = 5'd0; id_rs = 5'd0;
        chk_outs("lu_r0_nostall", O_DEF);
        // rt match ignored when not a source
        ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 1'b0;
        chk_outs("lu_rt_unused", O_DEF);
        id_uses_rt = 1'b1;
        chk_outs("lu_rt_used", O_LU);
        tick();
        chk_state("lu_rt_state", 2'd1);
        clear_inputs();
        tick();
        chk_state("lu_rt_run", 2'd0);

        // taken branch with simultaneous load-use hazard
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; mem_branch_taken = 1'b1;
        chk_outs("branch_over_lu", O_BR);
        tick();
        chk_state("branch_flush_state", 2'd3);
        clear_inputs();
        chk_outs("flush_defaults", O_DEF);
        tick();
        chk_state("flush_to_run", 2'd0);

        // memory wait of 3 frozen cycles
        mem_access = 1'b1; dmem_ready = 1'b0;
        chk_outs("wait_c1", O_WAIT);
        tick();
        chk_state("wait_s1", 2'd2);
        chk_outs("wait_c2", O_WAIT);
        tick();
        chk_outs("wait_c3", O_WAIT);
        tick();
        dmem_ready = 1'b1;
        chk_outs("wait_exit", O_DEFMR);
        chk_state("wait_exit_state", 2'd2);
        tick();
        chk_state("wait_done", 2'd0);
        chk_err("wait_no_err", 1'b0);
`ifdef PERF_COUNTERS_EN
        n_checks++;
        assert (wait_cnt === 16'd3) else begin
            n_fail++;
            $error("FAIL wait_cnt observed=%0d expected=3", wait_cnt);
        end
`endif

        // timeout: memory wait outranks a taken branch
        mem_access = 1'b1; dmem_ready = 1'b0; mem_branch_taken = 1'b1;
        chk_outs("wait_over_branch", O_WAIT);
        for (int i = 1; i <= 15; i++) begin
            tick();
        end
        chk_err("tmo_after15", 1'b0);
        tick();
        chk_err("tmo_after16", 1'b1);
        tick();
        tick();
        chk_err("tmo_sticky", 1'b1);
        chk_state("tmo_state", 2'd2);
        reset = 1'b1;
        chk_outs("tmo_reset_outs", O_RST);
        tick();
        chk_state("tmo_reset_state", 2'd0);
        chk_err("tmo_reset_err", 1'b0);
        reset = 1'b0;
        clear_inputs();

        // reset during LU_STALL
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
        tick();
        chk_state("lu2_state", 2'd1);
        reset = 1'b1;
        chk_outs("lu2_reset_outs", O_RST);
        tick();
        reset = 1'b0;
        clear_inputs();
        chk_state("lu2_after_reset", 2'd0);
        chk_outs("lu2_defaults", O_DEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (fetch, decode, execute, mem, writeBack).
- Detects load-use hazards and inserts one bubble.
- Squashes wrong-path instructions on a taken branch resolved in MEM.
- Freezes the whole pipeline while data memory is busy.
- Drives the write enables and flushes of PC, IF_ID, ID_EX and EX_MEM.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on dmem_ready before mem_err asserts
CNT_W, 16, width of performance counters (used only with PERF_COUNTERS_EN)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous active-high reset
id_rs  input  5  rs field of the instruction in IF_ID
id_rt  input  5  rt field of the instruction in IF_ID
id_uses_rt  input  1  decode instruction reads rt as a source (R-type, beq, sw)
ex_mem_read  input  1  ID_EX holds a load (M field MemRead)
ex_rt  input  5  destination rt of the instruction in ID_EX
mem_branch_taken  input  1  EX_MEM Branch & zero flag
mem_access  input  1  EX_MEM holds a load or store
dmem_ready  input  1  data memory completes the access this cycle
pc_write  output  1  PC load enable
if_id_write  output  1  IF_ID load enable
if_id_flush  output  1  clear IF_ID to nop on next edge
id_ex_flush  output  1  clear ID_EX control fields (bubble)
ex_mem_flush  output  1  clear EX_MEM control fields
pipe_freeze  output  1  hold ID_EX, EX_MEM, MEM_WB
mem_req  output  1  data-memory access strobe
mem_err  output  1  sticky timeout flag
state  output  2  current FSM state (debug)

Behaviour:
- Clock is clk. Reset is synchronous and active-high, sampled on posedge clk.
- While reset=1, outputs are driven as follows:
  - pc_write=0, if_id_write=0.
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, so the pipeline registers clear on that edge.
  - pipe_freeze=0, mem_req=0.
- On the reset edge: state<=RUN, mem_err<=0, wait counter<=0.
- Reset mid-stall or mid-wait aborts immediately; there is no completion of a pending access.
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3.
- Control outputs are combinational from state and inputs (same-cycle effect). State, counter and mem_err are registered.
- Default outputs (no hazard): pc_write=1, if_id_write=1, all flushes 0, pipe_freeze=0.
- mem_req = mem_access, in every state except during reset.
- Priority when events coincide: reset > memory wait > taken branch > load-use.
- Memory wait: mem_access=1 and dmem_ready=0 in RUN, LU_STALL or FLUSH.
  - pipe_freeze=1, pc_write=0, if_id_write=0, all flushes 0.
  - Next state MEM_WAIT.
- MEM_WAIT:
  - Same outputs as memory wait; the wait counter increments each cycle.
  - dmem_ready=1: outputs as RUN this cycle (pipeline advances); counter<=0; next state RUN.
  - A branch in EX_MEM stays frozen during the wait and is evaluated in the exit cycle with normal branch rules.
  - Counter reaching MEM_TIMEOUT-1: mem_err<=1 (sticky until reset); state stays MEM_WAIT.
- Taken branch (mem_branch_taken=1, no memory wait):
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - pc_write=1 (PC loads the branch target selected by the fetch mux).
  - Next state FLUSH.
  - Any load-use hazard in the same cycle is ignored, because the offending instructions are squashed.
- FLUSH: lasts exactly 1 cycle; default outputs; then RUN. Used for observability and to block a back-to-back stall on squashed fields.
- Load-use hazard, in RUN only:
  - Condition: ex_mem_read=1 and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
  - pc_write=0, if_id_write=0, id_ex_flush=1; next state LU_STALL.
- LU_STALL: lasts exactly 1 cycle; default outputs, even if the hazard equation is still true; then RUN.
- Register 0 never causes a hazard.

Optional Feature:
- Macro: PERF_COUNTERS_EN.
- Defined, adds these outputs (all reset to 0, saturating at all-ones):
  - stall_cnt, CNT_W bits: increments each cycle with pc_write=0 outside reset.
  - flush_cnt, CNT_W bits: increments on each taken-branch flush.
  - wait_cnt, CNT_W bits: increments each MEM_WAIT cycle.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- lw $2 in ID_EX (ex_mem_read=1, ex_rt=2), decode add with id_rs=2 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, state=1; next cycle all defaults, state=0.
- Same as above but ex_rt=0, or ex_rt=5 with id_uses_rt=0 and id_rt=5 -> no stall; pc_write stays 1.
- mem_branch_taken=1 while a load-use hazard is also present -> all three flushes=1, pc_write=1, state=3 next cycle, no stall asserted.
- mem_access=1, dmem_ready low for 3 cycles then high -> pipe_freeze=1 for 3 cycles, state=2; exit cycle has pipe_freeze=0, state returns 0; with PERF_COUNTERS_EN, wait_cnt=3.
- dmem_ready held low, MEM_TIMEOUT=16 -> mem_err rises after 16 wait cycles and stays high; reset pulse clears it and forces state=0 on the same edge.
- reset asserted during LU_STALL -> that cycle shows all flushes=1, pc_write=0; after release, state=0 and defaults resume.
